// File: rtl/robot_pkg.sv
// robot_pkg: shared state codes, orientation codes and default timing constants
// for the pipe-cleaning robot controller.
package robot_pkg;
    typedef enum logic [2:0] {
        SEARCH     = 3'b000,
        ROTATE     = 3'b001,
        FOLLOW     = 3'b010,
        STANDBY    = 3'b011,
        FIRST_MOVE = 3'b100,
        RESETING   = 3'b101
    } state_t;
    typedef enum logic [1:0] {
        ORI_N = 2'b00,
        ORI_S = 2'b01,
        ORI_E = 2'b10,
        ORI_W = 2'b11
    } orient_t;
    localparam int DEF_REMOVE_CYCLES = 3;
    localparam int DEF_RTURN_STEPS   = 3;
    localparam int DEF_SPIN_MAX      = 12;
endpackage

// File: rtl/pipe_robot_controller_if.sv
// pipe_robot_controller_if: sensor/actuator bundle between the controller (master) and the plant (slave).
interface pipe_robot_controller_if;
    logic head;
    logic left;
    logic under;
    logic barrier;
    logic front;
    logic turn;
    logic remove;
    modport master (input head, left, under, barrier, output front, turn, remove);
    modport slave (output head, left, under, barrier, input front, turn, remove);
endinterface

// File: rtl/robot_step_counter.sv
// robot_step_counter: loadable saturating up-counter with terminal flag and async active-low clear.
module robot_step_counter #(
    parameter int MAX = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic load_i,
    input  logic inc_i,
    output logic term_o
);
    localparam int W = $clog2(MAX + 1);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else if (load_i) cnt_q <= W'(1);
        else if (inc_i && !term_o) cnt_q <= cnt_q + 1'b1;
    end
    assign term_o = cnt_q == W'(MAX);
endmodule

// File: rtl/pipe_robot_controller.sv
// pipe_robot_controller: left-wall-following navigation FSM that clears trash ahead and
// parks on the exit mark; one registered action per cycle.
module pipe_robot_controller
    import robot_pkg::*;
#(
    parameter int REMOVE_CYCLES = DEF_REMOVE_CYCLES,
    parameter int RTURN_STEPS   = DEF_RTURN_STEPS,
    parameter int SPIN_MAX      = DEF_SPIN_MAX
) (
    input logic clock,
    input logic reset,
    pipe_robot_controller_if.master bus
);
    localparam int SW = $clog2(SPIN_MAX + 1);
    state_t act_state, next_state;
    logic front_d, turn_d, remove_d;
    logic tl_q, tl_d;
    logic [SW-1:0] spin_q, spin_d;
    logic rm_load, rm_term, rot_load, rot_term;
    robot_step_counter #(.MAX(REMOVE_CYCLES)) u_rm (
        .clock (clock),
        .reset (reset),
        .load_i(rm_load),
        .inc_i (remove_d && act_state == FOLLOW),
        .term_o(rm_term)
    );
    robot_step_counter #(.MAX(RTURN_STEPS)) u_rot (
        .clock (clock),
        .reset (reset),
        .load_i(rot_load),
        .inc_i (turn_d && act_state == ROTATE),
        .term_o(rot_term)
    );
    always_comb begin
        next_state = act_state;
        front_d    = 1'b0;
        turn_d     = 1'b0;
        remove_d   = 1'b0;
        tl_d       = tl_q;
        rm_load    = 1'b0;
        rot_load   = 1'b0;
        // Watchdog: boxed in after too many consecutive turns
        if (spin_q == SW'(SPIN_MAX) && act_state != RESETING) next_state = STANDBY;
        else case (act_state)
            RESETING: next_state = FIRST_MOVE;
            FIRST_MOVE, SEARCH: begin
                if (bus.under) next_state = STANDBY;
                else if (bus.barrier) begin
                    next_state = FOLLOW;
                    remove_d   = 1'b1;
                    rm_load    = 1'b1;
                end else if (act_state == SEARCH && !bus.left && !tl_q) begin
                    turn_d = 1'b1;
                    tl_d   = 1'b1;
                end else if (bus.head) begin
                    next_state = ROTATE;
                    turn_d     = 1'b1;
                    rot_load   = 1'b1;
                end else begin
                    front_d    = 1'b1;
                    tl_d       = 1'b0;
                    next_state = (act_state == FIRST_MOVE && !bus.left) ? FIRST_MOVE : SEARCH;
                end
            end
            ROTATE: begin
                next_state = rot_term ? SEARCH : ROTATE;
                turn_d     = !rot_term;
            end
            FOLLOW: begin
                next_state = !rm_term ? FOLLOW : bus.under ? STANDBY : SEARCH;
                remove_d   = !rm_term;
            end
            default: next_state = STANDBY;
        endcase
        spin_d = turn_d ? (spin_q == SW'(SPIN_MAX) ? spin_q : spin_q + 1'b1) :
                 (front_d || remove_d) ? '0 : spin_q;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            act_state  <= RESETING;
            tl_q       <= 1'b0;
            spin_q     <= '0;
            bus.front  <= 1'b0;
            bus.turn   <= 1'b0;
            bus.remove <= 1'b0;
        end else begin
            act_state  <= next_state;
            tl_q       <= tl_d;
            spin_q     <= spin_d;
            bus.front  <= front_d;
            bus.turn   <= turn_d;
            bus.remove <= remove_d;
        end
    end
endmodule
